// File: rtl/lvds_word_align_if.sv
// Byte-alignment bus for lvds_word_align: sliding window in, aligned bytes and status out.
`timescale 1ns/1ps
interface lvds_word_align_if;
   logic [7:0] i_lvds_d;
   logic [7:0] o_byte;
   logic       o_byte_vld;
   logic       o_sof;
   logic       o_locked;
   logic [7:0] o_sync_err_cnt;

   modport master (
      output i_lvds_d,
      input  o_byte, o_byte_vld, o_sof, o_locked, o_sync_err_cnt
   );

   modport slave (
      input  i_lvds_d,
      output o_byte, o_byte_vld, o_sof, o_locked, o_sync_err_cnt
   );
endinterface

// File: rtl/lvds_word_align.sv
// LVDS word aligner: hunts for SYNC_WORD in the sliding window, confirms, locks, emits bytes.
// Optional saturating sync-miss counter built only when LVDS_ALIGN_ERRCNT_EN is defined.
//
// state     | meaning
// S_HUNT    | compare window against SYNC_WORD every cycle
// S_CONFIRM | candidate found; waiting for CONFIRM_N hits at frame spacing
// S_LOCKED  | aligned; emit one byte per boundary, count sync misses
`timescale 1ns/1ps
module lvds_word_align #(
   parameter logic [7:0] SYNC_WORD = 8'h47,
   parameter int         FRAME_LEN = 16,
   parameter int         CONFIRM_N = 2,
   parameter int         LOSS_N    = 3
) (
   input  logic                lvds_clk,
   input  logic                rst_n,
   lvds_word_align_if.slave    bus
);

   localparam int IDX_W  = $clog2(FRAME_LEN);
   localparam int HIT_W  = $clog2(CONFIRM_N + 1);
   localparam int MISS_W = $clog2(LOSS_N + 1);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
   localparam logic [HIT_W-1:0]  HIT_DONE  = HIT_W'(CONFIRM_N);
   localparam logic [MISS_W-1:0] MISS_DONE = MISS_W'(LOSS_N);

   typedef enum logic [1:0] {S_HUNT, S_CONFIRM, S_LOCKED} state_t;

   state_t              r_state, w_state_nxt;
   logic [2:0]          r_bit_cnt, w_bit_cnt_nxt;
   logic [IDX_W-1:0]    r_byte_idx, w_byte_idx_nxt, w_idx_adv;
   logic [HIT_W-1:0]    r_hit_cnt, w_hit_cnt_nxt, w_hit_inc;
   logic [MISS_W-1:0]   r_miss_cnt, w_miss_cnt_nxt, w_miss_inc;

   logic                w_match, w_bnd, w_idx0, w_loss;
   logic                w_emit, w_sof;

   logic [7:0]          r_byte;
   logic                r_byte_vld, r_sof, r_locked;

   assign w_match    = (bus.i_lvds_d == SYNC_WORD);
   assign w_bnd      = (r_bit_cnt == 3'd7);
   assign w_idx0     = (r_byte_idx == '0);
   assign w_idx_adv  = (r_byte_idx == IDX_LAST) ? '0 : r_byte_idx + IDX_ONE;
   assign w_hit_inc  = r_hit_cnt + HIT_W'(1);
   assign w_miss_inc = r_miss_cnt + MISS_W'(1);
   assign w_loss     = (r_state == S_LOCKED) && w_bnd && w_idx0 && !w_match
                       && (w_miss_inc == MISS_DONE);

   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_HUNT;
      else        r_state <= w_state_nxt;
   end

   // byte_idx holds the index of the byte that will sit in the window at the next boundary
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
      w_byte_idx_nxt = r_byte_idx;
      w_hit_cnt_nxt  = r_hit_cnt;
      w_miss_cnt_nxt = r_miss_cnt;
      unique case (r_state)
         S_HUNT: begin
            if (w_match) begin
               w_bit_cnt_nxt  = '0;
               w_byte_idx_nxt = IDX_ONE;
               w_hit_cnt_nxt  = HIT_W'(1);
               w_miss_cnt_nxt = '0;
               w_state_nxt    = (CONFIRM_N == 1) ? S_LOCKED : S_CONFIRM;
            end
         end
         S_CONFIRM: begin
            if (w_bnd) begin
               w_byte_idx_nxt = w_idx_adv;
               if (w_idx0) begin
                  if (w_match) begin
                     w_hit_cnt_nxt = w_hit_inc;
                     if (w_hit_inc == HIT_DONE) w_state_nxt = S_LOCKED;
                  end else begin
                     w_state_nxt    = S_HUNT;
                     w_bit_cnt_nxt  = '0;
                     w_byte_idx_nxt = '0;
                     w_hit_cnt_nxt  = '0;
                  end
               end
            end
         end
         S_LOCKED: begin
            if (w_bnd) begin
               w_byte_idx_nxt = w_idx_adv;
               if (w_idx0) begin
                  if (w_match) begin
                     w_miss_cnt_nxt = '0;
                  end else if (w_loss) begin
                     w_state_nxt    = S_HUNT;
                     w_bit_cnt_nxt  = '0;
                     w_byte_idx_nxt = '0;
                     w_hit_cnt_nxt  = '0;
                     w_miss_cnt_nxt = '0;
                  end else begin
                     w_miss_cnt_nxt = w_miss_inc;
                  end
               end
            end
         end
         default: w_state_nxt = S_HUNT;
      endcase
   end

   // Locking transitions emit their sync byte; a lock-dropping miss emits nothing
   always_comb begin
      w_emit = 1'b0;
      w_sof  = 1'b0;
      unique case (r_state)
         S_HUNT: begin
            w_emit = w_match && (CONFIRM_N == 1);
            w_sof  = w_emit;
         end
         S_CONFIRM: begin
            w_emit = w_bnd && w_idx0 && w_match && (w_hit_inc == HIT_DONE);
            w_sof  = w_emit;
         end
         S_LOCKED: begin
            w_emit = w_bnd && !w_loss;
            w_sof  = w_emit && w_idx0;
         end
         default: begin
            w_emit = 1'b0;
            w_sof  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt  <= '0;
         r_byte_idx <= '0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         r_byte     <= 8'h00;
         r_byte_vld <= 1'b0;
         r_sof      <= 1'b0;
         r_locked   <= 1'b0;
      end else begin
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_hit_cnt  <= w_hit_cnt_nxt;
         r_miss_cnt <= w_miss_cnt_nxt;
         r_byte_vld <= w_emit;
         r_sof      <= w_sof;
         r_locked   <= (w_state_nxt == S_LOCKED);
         if (w_emit) r_byte <= bus.i_lvds_d;
      end
   end

   assign bus.o_byte     = r_byte;
   assign bus.o_byte_vld = r_byte_vld;
   assign bus.o_sof      = r_sof;
   assign bus.o_locked   = r_locked;

`ifdef LVDS_ALIGN_ERRCNT_EN
   logic [7:0] r_err_cnt;
   logic       w_err_inc;

   assign w_err_inc = (r_state == S_LOCKED) && w_bnd && w_idx0 && !w_match;

   // survives loss of lock; only reset clears it
   always_ff @(posedge lvds_clk or negedge rst_n) begin
      if (!rst_n)                             r_err_cnt <= 8'h00;
      else if (w_err_inc && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
   end

   assign bus.o_sync_err_cnt = r_err_cnt;
`else
   assign bus.o_sync_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lvds_word_align.sv
// Directed bench for lvds_word_align: serial frames shifted MSB-first into an 8-bit window.
`timescale 1ns/1ps
module tb_lvds_word_align;

`ifdef LVDS_ALIGN_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic lvds_clk = 1'b0;
   logic rst_n;
   logic rst6_n;

   always #5 lvds_clk = ~lvds_clk;

   lvds_word_align_if bus  ();
   lvds_word_align_if bus6 ();

   lvds_word_align u_dut (
      .lvds_clk (lvds_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   lvds_word_align #(.FRAME_LEN(2), .CONFIRM_N(1)) u_dut6 (
      .lvds_clk (lvds_clk),
      .rst_n    (rst6_n),
      .bus      (bus6)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [7:0] window;
   logic prev_lock, prev_lock6;
   int lock_cyc, unlock_cyc, unlock_cnt, lock6_cyc;

   int         lg_cyc[$];
   logic [7:0] lg_byte[$];
   logic       lg_sof[$];
   logic [7:0] lg_err[$];
   int         lg6_cyc[$];
   logic [7:0] lg6_byte[$];
   logic       lg6_sof[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] e_err(input int n);
      return ERR_EN ? 32'(n) : 32'd0;
   endfunction

   // window value for cycle n is applied at the falling edge; outputs read there belong to cycle n
   task automatic shift_bit(input logic b);
      @(negedge lvds_clk);
      cyc++;
      window = {window[6:0], b};
      bus.i_lvds_d  = window;
      bus6.i_lvds_d = window;
      if (bus.o_byte_vld) begin
         lg_cyc.push_back(cyc);
         lg_byte.push_back(bus.o_byte);
         lg_sof.push_back(bus.o_sof);
         lg_err.push_back(bus.o_sync_err_cnt);
      end
      if (bus.o_locked && !prev_lock) lock_cyc = cyc;
      if (!bus.o_locked && prev_lock) begin
         unlock_cyc = cyc;
         unlock_cnt++;
      end
      prev_lock = bus.o_locked;
      if (bus6.o_byte_vld) begin
         lg6_cyc.push_back(cyc);
         lg6_byte.push_back(bus6.o_byte);
         lg6_sof.push_back(bus6.o_sof);
      end
      if (bus6.o_locked && !prev_lock6) lock6_cyc = cyc;
      prev_lock6 = bus6.o_locked;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) shift_bit(v[i]);
   endtask

   task automatic send_frame(input logic [7:0] s, output int sync_cyc);
      send_byte(s);
      sync_cyc = cyc;
      for (int k = 0; k < 15; k++) send_byte(8'(k));
   endtask

   function automatic int find_entry(input int c);
      foreach (lg_cyc[i]) if (lg_cyc[i] == c) return i;
      return -1;
   endfunction

   function automatic int find_entry6(input int c);
      foreach (lg6_cyc[i]) if (lg6_cyc[i] == c) return i;
      return -1;
   endfunction

   task automatic chk_entry(input string tag, input int c, input logic [7:0] b,
                            input logic s, input logic [31:0] e);
      int idx;
      idx = find_entry(c);
      chk({tag, "_vld"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         chk({tag, "_byte"}, 32'(lg_byte[idx]), 32'(b));
         chk({tag, "_sof"},  32'(lg_sof[idx]),  32'(s));
         chk({tag, "_err"},  32'(lg_err[idx]),  e);
      end
   endtask

   task automatic chk_entry6(input string tag, input int c, input logic [7:0] b, input logic s);
      int idx;
      idx = find_entry6(c);
      chk({tag, "_vld"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         chk({tag, "_byte"}, 32'(lg6_byte[idx]), 32'(b));
         chk({tag, "_sof"},  32'(lg6_sof[idx]),  32'(s));
      end
   endtask

   task automatic clear_logs();
      lg_cyc.delete();
      lg_byte.delete();
      lg_sof.delete();
      lg_err.delete();
      lock_cyc   = -1;
      unlock_cyc = -1;
      unlock_cnt = 0;
   endtask

   task automatic do_reset();
      @(negedge lvds_clk);
      rst_n = 1'b0;
      repeat (2) @(negedge lvds_clk);
      rst_n     = 1'b1;
      prev_lock = 1'b0;
      clear_logs();
   endtask

   initial begin
      int t1, t2, t3, b1, b2, b3, f;
      int x1, g1, x2, g2, x3, g3, s;
      int bad;
      int idx;

      rst_n  = 1'b0;
      rst6_n = 1'b0;
      window = 8'hFF;
      bus.i_lvds_d  = 8'hFF;
      bus6.i_lvds_d = 8'hFF;
      prev_lock  = 1'b0;
      prev_lock6 = 1'b0;
      lock6_cyc  = -1;
      clear_logs();

      // reset state
      repeat (3) @(negedge lvds_clk);
      chk("rst_byte",   32'(bus.o_byte),         32'd0);
      chk("rst_vld",    32'(bus.o_byte_vld),     32'd0);
      chk("rst_sof",    32'(bus.o_sof),          32'd0);
      chk("rst_locked", 32'(bus.o_locked),       32'd0);
      chk("rst_err",    32'(bus.o_sync_err_cnt), 32'd0);
      rst_n = 1'b1;

      // 1: clean frames, lock two frames after first sync
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_frame(8'h47, t1);
      send_frame(8'h47, t2);
      send_frame(8'h47, t3);
      chk("s1_lock_cyc", 32'(lock_cyc), 32'(t1 + 129));
      chk_entry("s1_first", t1 + 129, 8'h47, 1'b1, 32'd0);
      chk_entry("s1_second", t1 + 137, 8'h00, 1'b0, 32'd0);
      chk_entry("s1_last_payload", t1 + 249, 8'h0E, 1'b0, 32'd0);
      chk_entry("s1_frame3_sync", t1 + 257, 8'h47, 1'b1, 32'd0);
      chk("s1_nvld", 32'(lg_cyc.size()), 32'd31);
      bad = 0;
      for (int i = 1; i < lg_cyc.size(); i++) if (lg_cyc[i] - lg_cyc[i-1] != 8) bad++;
      chk("s1_spacing", 32'(bad), 32'd0);

      // 2: false sync in payload, then true lock
      do_reset();
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'h47);
      f = cyc;
      for (int k = 0; k < 15; k++) send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'hFF);
      chk("s2_false_gap", 32'(cyc - f), 32'd136);
      chk("s2_no_vld", 32'(lg_cyc.size()), 32'd0);
      chk("s2_unlocked", 32'(bus.o_locked), 32'd0);
      send_frame(8'h47, t1);
      send_frame(8'h47, t2);
      chk("s2_lock_cyc", 32'(lock_cyc), 32'(t1 + 129));
      chk_entry("s2_first", t1 + 129, 8'h47, 1'b1, 32'd0);

      // 3: three consecutive missed syncs drop lock
      send_frame(8'h47, t3);
      send_frame(8'h00, b1);
      send_frame(8'h00, b2);
      send_frame(8'h00, b3);
      send_byte(8'hFF);
      chk_entry("s3_miss1", b1 + 1, 8'h00, 1'b1, e_err(1));
      chk_entry("s3_miss1_next", b1 + 9, 8'h00, 1'b0, e_err(1));
      chk_entry("s3_miss2", b2 + 1, 8'h00, 1'b1, e_err(2));
      chk("s3_miss3_novld", 32'(find_entry(b3 + 1)), 32'hFFFF_FFFF);
      chk("s3_last_vld", 32'(lg_cyc[lg_cyc.size()-1]), 32'(b3 - 7));
      chk("s3_unlock_cyc", 32'(unlock_cyc), 32'(b3 + 1));
      chk("s3_locked", 32'(bus.o_locked), 32'd0);
      chk("s3_err", 32'(bus.o_sync_err_cnt), e_err(3));

      // 4: isolated misses never drop lock
      do_reset();
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_frame(8'h47, t1);
      send_frame(8'h47, t2);
      send_frame(8'h00, x1);
      send_frame(8'h47, g1);
      send_frame(8'h00, x2);
      send_frame(8'h47, g2);
      send_frame(8'h00, x3);
      send_frame(8'h47, g3);
      chk_entry("s4_miss1", x1 + 1, 8'h00, 1'b1, e_err(1));
      chk_entry("s4_good1", g1 + 1, 8'h47, 1'b1, e_err(1));
      chk_entry("s4_miss3", x3 + 1, 8'h00, 1'b1, e_err(3));
      chk_entry("s4_good3", g3 + 1, 8'h47, 1'b1, e_err(3));
      chk("s4_unlock_cnt", 32'(unlock_cnt), 32'd0);
      chk("s4_locked", 32'(bus.o_locked), 32'd1);

      // 5: async reset mid-frame while locked
      send_byte(8'h47);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      #7;
      chk("s5_pre_byte", 32'(bus.o_byte), 32'h02);
      chk("s5_pre_locked", 32'(bus.o_locked), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("s5_rst_byte",   32'(bus.o_byte),         32'd0);
      chk("s5_rst_vld",    32'(bus.o_byte_vld),     32'd0);
      chk("s5_rst_sof",    32'(bus.o_sof),          32'd0);
      chk("s5_rst_locked", 32'(bus.o_locked),       32'd0);
      chk("s5_rst_err",    32'(bus.o_sync_err_cnt), 32'd0);
      #29;
      rst_n     = 1'b1;
      prev_lock = 1'b0;
      clear_logs();
      window = 8'hFF;
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_frame(8'h47, t1);
      chk("s5_not_yet_locked", 32'(bus.o_locked), 32'd0);
      send_frame(8'h47, t2);
      chk("s5_relock_cyc", 32'(lock_cyc), 32'(t1 + 129));
      chk_entry("s5_first", t1 + 129, 8'h47, 1'b1, 32'd0);

      // 6: CONFIRM_N=1, FRAME_LEN=2 instance
      @(negedge lvds_clk);
      rst6_n = 1'b1;
      lg6_cyc.delete();
      lg6_byte.delete();
      lg6_sof.delete();
      send_byte(8'hFF);
      send_byte(8'hFF);
      send_byte(8'h47);
      s = cyc;
      send_byte(8'h5A);
      send_byte(8'h47);
      send_byte(8'h5A);
      send_byte(8'h47);
      send_byte(8'h5A);
      chk("s6_lock_cyc", 32'(lock6_cyc), 32'(s + 1));
      chk_entry6("s6_sync0", s + 1,  8'h47, 1'b1);
      chk_entry6("s6_pay0",  s + 9,  8'h5A, 1'b0);
      chk_entry6("s6_sync1", s + 17, 8'h47, 1'b1);
      chk_entry6("s6_pay1",  s + 25, 8'h5A, 1'b0);
      chk_entry6("s6_sync2", s + 33, 8'h47, 1'b1);
      idx = find_entry6(s + 1);
      chk("s6_first_is_first", 32'(idx), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
